// File: rtl/mac_dot_seq.sv
// mac_dot_seq
//   Operand sequencer for a 16-bit fixed-point MAC. A command (start + len)
//   clears the MAC, streams len operand pairs from two synchronous-read
//   RAMs into the MAC, feeds zeros while the MAC pipeline drains, then
//   captures mac_acc into result and pulses done for one cycle.
//
//   Optional feature: define MAC_DOT_SAT_FLAG_EN to add the sat_flag output,
//   which reports whether the captured accumulator sits at a saturation rail.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   start, len        command strobe (accepted only in IDLE) and pair count
//   busy, done        busy in CLEAR/FEED/DRAIN; one-cycle done pulse
//   result            captured accumulator, held until the next capture
//   mem_en, mem_addr  shared read port to the A and B operand RAMs
//   mem_a/b_rdata     RAM read data, valid the cycle after mem_en
//   mac_a, mac_b      registered operands to the MAC (zero when idle)
//   mac_rst_n         active-low MAC clear
//   mac_acc           MAC accumulator output
//   sat_flag          (MAC_DOT_SAT_FLAG_EN only) result is at +/- full scale
module mac_dot_seq #(
  parameter int ADDR_W  = 8,
  parameter int MAC_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [15:0]       result,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_a_rdata,
  input  logic [15:0]       mem_b_rdata,
  output logic [15:0]       mac_a,
  output logic [15:0]       mac_b,
  output logic              mac_rst_n,
  input  logic [15:0]       mac_acc
`ifdef MAC_DOT_SAT_FLAG_EN
  ,
  output logic              sat_flag
`endif
);

  // Two extra drain cycles cover the RAM read and the operand register.
  localparam int DRAIN_CYC = MAC_LAT + 2;
  localparam int DRAIN_W   = $clog2(DRAIN_CYC + 1);

  localparam logic [ADDR_W:0]    CNT_ONE    = (ADDR_W + 1)'(1);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  // Address counter is one bit wider than mem_addr so len = 2^ADDR_W
  // reaches its last address without wrapping.
  logic [ADDR_W:0]    len_reg;
  logic [ADDR_W:0]    addr_reg;
  logic [DRAIN_W-1:0] drain_reg;
  logic               valid_reg;
  logic [15:0]        mac_a_reg;
  logic [15:0]        mac_b_reg;
  logic [15:0]        result_reg;
  logic               mac_clr;
  logic               feed_last;
  logic               drain_last;

  assign feed_last  = (addr_reg == len_reg - CNT_ONE);
  assign drain_last = (drain_reg == DRAIN_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    mem_en     = 1'b0;
    mac_clr    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          // An empty command skips the MAC entirely and reports zero.
          state_next = (len != '0) ? S_CLEAR : S_DONE;
        end
      end
      S_CLEAR: begin
        busy       = 1'b1;
        mac_clr    = 1'b1;
        state_next = S_FEED;
      end
      S_FEED: begin
        busy   = 1'b1;
        mem_en = 1'b1;
        if (feed_last) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_last) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_reg    <= '0;
      addr_reg   <= '0;
      drain_reg  <= '0;
      valid_reg  <= 1'b0;
      mac_a_reg  <= '0;
      mac_b_reg  <= '0;
      result_reg <= '0;
`ifdef MAC_DOT_SAT_FLAG_EN
      sat_flag   <= 1'b0;
`endif
    end else begin
      // Read data is only meaningful the cycle after mem_en; otherwise zero
      // operands keep the accumulator still.
      valid_reg <= mem_en;
      mac_a_reg <= valid_reg ? mem_a_rdata : 16'h0000;
      mac_b_reg <= valid_reg ? mem_b_rdata : 16'h0000;

      case (state_reg)
        S_IDLE: begin
          if (start) begin
            len_reg <= len;
            if (len == '0) begin
              result_reg <= 16'h0000;
`ifdef MAC_DOT_SAT_FLAG_EN
              sat_flag   <= 1'b0;
`endif
            end
          end
        end
        S_CLEAR: begin
          addr_reg  <= '0;
          drain_reg <= '0;
        end
        S_FEED: begin
          addr_reg <= feed_last ? '0 : addr_reg + CNT_ONE;
        end
        S_DRAIN: begin
          drain_reg <= drain_reg + DRAIN_ONE;
          if (drain_last) begin
            result_reg <= mac_acc;
`ifdef MAC_DOT_SAT_FLAG_EN
            sat_flag   <= (mac_acc == 16'h7FFF) || (mac_acc == 16'h8001);
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_addr  = addr_reg[ADDR_W-1:0];
  assign mac_a     = mac_a_reg;
  assign mac_b     = mac_b_reg;
  assign result    = result_reg;
  // The MAC is held cleared while the sequencer itself is in reset.
  assign mac_rst_n = rst & ~mac_clr;

endmodule

// File: tb/tb_mac_dot_seq.sv
// tb_mac_dot_seq
//   Bench for mac_dot_seq. Provides behavioural operand RAMs and a
//   behavioural saturating MAC (product >>> 9, accumulator clamped to
//   +/-32767, MAC_LAT cycles of latency). Expected results come from a
//   plain loop over the RAM contents using the same MAC arithmetic.
module tb_mac_dot_seq;
  localparam int ADDR_W  = 8;
  localparam int MAC_LAT = 4;
  localparam int DEPTH   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic [15:0]       result;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_a_rdata;
  logic [15:0]       mem_b_rdata;
  logic [15:0]       mac_a;
  logic [15:0]       mac_b;
  logic              mac_rst_n;
  logic [15:0]       mac_acc;
`ifdef MAC_DOT_SAT_FLAG_EN
  logic              sat_flag;
`endif

  always #5 clk = ~clk;

  mac_dot_seq #(.ADDR_W(ADDR_W), .MAC_LAT(MAC_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .len         (len),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .mem_en      (mem_en),
    .mem_addr    (mem_addr),
    .mem_a_rdata (mem_a_rdata),
    .mem_b_rdata (mem_b_rdata),
    .mac_a       (mac_a),
    .mac_b       (mac_b),
    .mac_rst_n   (mac_rst_n),
    .mac_acc     (mac_acc)
`ifdef MAC_DOT_SAT_FLAG_EN
    ,
    .sat_flag    (sat_flag)
`endif
  );

  // ---------------- environment models ----------------
  logic [15:0] mem_a [DEPTH];
  logic [15:0] mem_b [DEPTH];

  always @(posedge clk) begin
    if (mem_en) begin
      mem_a_rdata <= mem_a[mem_addr];
      mem_b_rdata <= mem_b[mem_addr];
    end
  end

  function automatic int prod(input logic [15:0] a, input logic [15:0] b);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return (sa * sb) >>> 9;
  endfunction

  function automatic int sat16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32767) return -32767;
    return v;
  endfunction

  int          mac_sum;
  logic [15:0] mac_p0, mac_p1, mac_p2;
  always @(posedge clk) begin
    if (!mac_rst_n) begin
      mac_sum <= 0;
      mac_p0  <= '0;
      mac_p1  <= '0;
      mac_p2  <= '0;
    end else begin
      mac_sum <= sat16(mac_sum + prod(mac_a, mac_b));
      mac_p0  <= mac_sum[15:0];
      mac_p1  <= mac_p0;
      mac_p2  <= mac_p1;
    end
  end
  assign mac_acc = mac_p2;

  function automatic logic [15:0] ref_dot(input int l);
    int acc;
    acc = 0;
    for (int i = 0; i < l; i++) acc = sat16(acc + prod(mem_a[i], mem_b[i]));
    return acc[15:0];
  endfunction

  // ---------------- command driver / observer ----------------
  int n_checks = 0;
  int n_fail   = 0;

  int          obs_done_cyc, obs_busy_first, obs_busy_last, obs_busy_cnt;
  int          obs_clr_cnt, obs_clr_cyc, obs_en_cnt, obs_addr_err;
  logic [15:0] obs_result;
  logic        obs_sat;

  // Issues one command; cycle 1 is the cycle after the edge that samples
  // start. Returns at the negedge of the done cycle (or after a timeout).
  task automatic run_cmd(input int l, input int repulse_cyc);
    int exp_addr;
    exp_addr = 0;
    obs_done_cyc = -1; obs_busy_first = -1; obs_busy_last = -1; obs_busy_cnt = 0;
    obs_clr_cnt = 0; obs_clr_cyc = -1; obs_en_cnt = 0; obs_addr_err = 0;
    obs_result = 'x; obs_sat = 1'bx;
    @(negedge clk);
    start = 1'b1;
    len   = l[ADDR_W:0];
    for (int cyc = 1; cyc <= 600; cyc++) begin
      @(negedge clk);
      start = (cyc == repulse_cyc);
      if (busy) begin
        if (obs_busy_first < 0) obs_busy_first = cyc;
        obs_busy_last = cyc;
        obs_busy_cnt++;
      end
      if (!mac_rst_n) begin
        obs_clr_cnt++;
        if (obs_clr_cyc < 0) obs_clr_cyc = cyc;
      end
      if (mem_en) begin
        if (mem_addr !== exp_addr[ADDR_W-1:0]) obs_addr_err++;
        exp_addr++;
        obs_en_cnt++;
      end
      if (done) begin
        obs_done_cyc = cyc;
        obs_result   = result;
`ifdef MAC_DOT_SAT_FLAG_EN
        obs_sat      = sat_flag;
`endif
        break;
      end
    end
    start = 1'b0;
    $display("run len=%0d: done_cyc=%0d result=%h busy=%0d..%0d reads=%0d clr=%0d",
             l, obs_done_cyc, obs_result, obs_busy_first, obs_busy_last, obs_en_cnt, obs_clr_cnt);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; start = 1'b0; len = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    n_checks++; if (done !== 1'b0)       begin n_fail++; $display("FAIL reset_done: got %b, expected 0", done); end
    n_checks++; if (result !== 16'h0)    begin n_fail++; $display("FAIL reset_result: got %h, expected 0000", result); end
    n_checks++; if (mem_en !== 1'b0)     begin n_fail++; $display("FAIL reset_mem_en: got %b, expected 0", mem_en); end
    n_checks++; if (mem_addr !== '0)     begin n_fail++; $display("FAIL reset_mem_addr: got %h, expected 0", mem_addr); end
    n_checks++; if ({mac_a, mac_b} !== 32'h0) begin n_fail++; $display("FAIL reset_mac_ops: got %h/%h, expected 0/0", mac_a, mac_b); end
    n_checks++; if (mac_rst_n !== 1'b0)  begin n_fail++; $display("FAIL reset_mac_rst_n: got %b, expected 0", mac_rst_n); end
`ifdef MAC_DOT_SAT_FLAG_EN
    n_checks++; if (sat_flag !== 1'b0)   begin n_fail++; $display("FAIL reset_sat_flag: got %b, expected 0", sat_flag); end
`endif
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (mac_rst_n !== 1'b1)  begin n_fail++; $display("FAIL idle_mac_rst_n: got %b, expected 1", mac_rst_n); end
  endtask

  task automatic test_len4();
    for (int i = 0; i < 4; i++) begin mem_a[i] = 16'h0200; mem_b[i] = 16'h0200; end
    run_cmd(4, -1);
    n_checks++; if (obs_done_cyc !== 12)     begin n_fail++; $display("FAIL len4_done_cyc: got %0d, expected 12", obs_done_cyc); end
    n_checks++; if (obs_result !== 16'h0800) begin n_fail++; $display("FAIL len4_result: got %h, expected 0800", obs_result); end
    n_checks++; if (obs_busy_first !== 1 || obs_busy_last !== 11 || obs_busy_cnt !== 11)
      begin n_fail++; $display("FAIL len4_busy: got %0d..%0d (%0d), expected 1..11 (11)", obs_busy_first, obs_busy_last, obs_busy_cnt); end
    n_checks++; if (obs_clr_cnt !== 1 || obs_clr_cyc !== 1)
      begin n_fail++; $display("FAIL len4_clear: got %0d cycles at %0d, expected 1 at 1", obs_clr_cnt, obs_clr_cyc); end
    n_checks++; if (obs_en_cnt !== 4 || obs_addr_err !== 0)
      begin n_fail++; $display("FAIL len4_reads: got %0d reads %0d bad, expected 4 reads 0 bad", obs_en_cnt, obs_addr_err); end
    repeat (3) @(negedge clk);
    n_checks++; if (result !== 16'h0800)     begin n_fail++; $display("FAIL len4_hold: got %h, expected 0800", result); end
  endtask

  task automatic test_cancel();
    mem_a[0] = 16'h0200; mem_a[1] = 16'hFE00;
    mem_b[0] = 16'h0200; mem_b[1] = 16'h0200;
    run_cmd(2, -1);
    n_checks++; if (obs_done_cyc !== 10)     begin n_fail++; $display("FAIL cancel_done_cyc: got %0d, expected 10", obs_done_cyc); end
    n_checks++; if (obs_result !== 16'h0000) begin n_fail++; $display("FAIL cancel_result: got %h, expected 0000", obs_result); end
`ifdef MAC_DOT_SAT_FLAG_EN
    n_checks++; if (obs_sat !== 1'b0)        begin n_fail++; $display("FAIL cancel_sat: got %b, expected 0", obs_sat); end
`endif
  endtask

  task automatic test_sat();
    mem_a[0] = 16'h7FFF; mem_a[1] = 16'h7FFF;
    mem_b[0] = 16'h7FFF; mem_b[1] = 16'h7FFF;
    run_cmd(2, -1);
    n_checks++; if (obs_result !== 16'h7FFF) begin n_fail++; $display("FAIL sat_pos_result: got %h, expected 7fff", obs_result); end
`ifdef MAC_DOT_SAT_FLAG_EN
    n_checks++; if (obs_sat !== 1'b1)        begin n_fail++; $display("FAIL sat_pos_flag: got %b, expected 1", obs_sat); end
`endif
    mem_b[0] = 16'h8001; mem_b[1] = 16'h8001;
    run_cmd(2, -1);
    n_checks++; if (obs_result !== 16'h8001) begin n_fail++; $display("FAIL sat_neg_result: got %h, expected 8001", obs_result); end
`ifdef MAC_DOT_SAT_FLAG_EN
    n_checks++; if (obs_sat !== 1'b1)        begin n_fail++; $display("FAIL sat_neg_flag: got %b, expected 1", obs_sat); end
`endif
  endtask

  task automatic test_len0();
    run_cmd(0, -1);
    n_checks++; if (obs_done_cyc !== 1)      begin n_fail++; $display("FAIL len0_done_cyc: got %0d, expected 1", obs_done_cyc); end
    n_checks++; if (obs_result !== 16'h0000) begin n_fail++; $display("FAIL len0_result: got %h, expected 0000", obs_result); end
    n_checks++; if (obs_en_cnt !== 0 || obs_clr_cnt !== 0 || obs_busy_cnt !== 0)
      begin n_fail++; $display("FAIL len0_quiet: got reads=%0d clr=%0d busy=%0d, expected 0/0/0", obs_en_cnt, obs_clr_cnt, obs_busy_cnt); end
`ifdef MAC_DOT_SAT_FLAG_EN
    n_checks++; if (obs_sat !== 1'b0)        begin n_fail++; $display("FAIL len0_sat: got %b, expected 0", obs_sat); end
`endif
  endtask

  task automatic test_back_to_back();
    int busy_seen;
    logic [15:0] exp;
    for (int i = 0; i < 3; i++) begin
      mem_a[i] = 16'($urandom_range(16'h0100, 16'h0400));
      mem_b[i] = 16'($urandom_range(16'h0100, 16'h0400));
    end
    exp = ref_dot(3);
    run_cmd(3, 3);  // start re-pulsed in the second FEED cycle
    n_checks++; if (obs_done_cyc !== 11)  begin n_fail++; $display("FAIL repulse_done_cyc: got %0d, expected 11", obs_done_cyc); end
    n_checks++; if (obs_result !== exp)   begin n_fail++; $display("FAIL repulse_result: got %h, expected %h", obs_result, exp); end
    // Start in the first IDLE cycle after DONE must be taken.
    exp = ref_dot(2);
    run_cmd(2, -1);
    n_checks++; if (obs_done_cyc !== 10)  begin n_fail++; $display("FAIL b2b_done_cyc: got %0d, expected 10", obs_done_cyc); end
    n_checks++; if (obs_result !== exp)   begin n_fail++; $display("FAIL b2b_result: got %h, expected %h", obs_result, exp); end
    // Start held during the DONE cycle must be dropped.
    start = 1'b1; len = 9'd2;
    busy_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy || done) busy_seen++;
    end
    n_checks++; if (busy_seen !== 0)      begin n_fail++; $display("FAIL done_start_ignored: got %0d active cycles, expected 0", busy_seen); end
  endtask

  task automatic test_reset_mid();
    int done_seen;
    int clr_high;
    for (int i = 0; i < 3; i++) begin mem_a[i] = 16'h0300; mem_b[i] = 16'h0300; end
    @(negedge clk); start = 1'b1; len = 9'd3;
    @(negedge clk); start = 1'b0;      // cycle 1 (CLEAR)
    @(negedge clk);                    // cycle 2 (FEED, addr 0)
    @(negedge clk);                    // cycle 3 (FEED, addr 1)
    rst = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL midrst_busy: got %b, expected 0", busy); end
    n_checks++; if (result !== 16'h0)   begin n_fail++; $display("FAIL midrst_result: got %h, expected 0000", result); end
    n_checks++; if (mem_en !== 1'b0)    begin n_fail++; $display("FAIL midrst_mem_en: got %b, expected 0", mem_en); end
    done_seen = 0; clr_high = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) done_seen++;
      if (mac_rst_n !== 1'b0) clr_high++;
    end
    n_checks++; if (clr_high !== 0)     begin n_fail++; $display("FAIL midrst_mac_rst_n: got %0d cycles high, expected 0", clr_high); end
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    n_checks++; if (done_seen !== 0)    begin n_fail++; $display("FAIL midrst_no_done: got %0d active cycles, expected 0", done_seen); end
    mem_a[0] = 16'h0200; mem_b[0] = 16'h0200;
    run_cmd(1, -1);
    n_checks++; if (obs_done_cyc !== 9)      begin n_fail++; $display("FAIL after_rst_done_cyc: got %0d, expected 9", obs_done_cyc); end
    n_checks++; if (obs_result !== 16'h0200) begin n_fail++; $display("FAIL after_rst_result: got %h, expected 0200", obs_result); end
  endtask

  task automatic test_random();
    int l;
    int v;
    logic [15:0] exp;
    for (int it = 0; it < 10; it++) begin
      l = (it == 0) ? DEPTH : int'($urandom_range(1, 40));
      for (int i = 0; i < l; i++) begin
        if (it % 2 == 1) begin
          mem_a[i] = 16'($urandom);
          mem_b[i] = 16'($urandom);
        end else begin
          v = int'($urandom_range(0, 1536)) - 768; mem_a[i] = v[15:0];
          v = int'($urandom_range(0, 1536)) - 768; mem_b[i] = v[15:0];
        end
      end
      exp = ref_dot(l);
      run_cmd(l, -1);
      n_checks++; if (obs_done_cyc !== l + 8) begin n_fail++; $display("FAIL rand%0d_done_cyc: got %0d, expected %0d", it, obs_done_cyc, l + 8); end
      n_checks++; if (obs_result !== exp)     begin n_fail++; $display("FAIL rand%0d_result: got %h, expected %h", it, obs_result, exp); end
      n_checks++; if (obs_en_cnt !== l || obs_addr_err !== 0)
        begin n_fail++; $display("FAIL rand%0d_reads: got %0d reads %0d bad, expected %0d reads 0 bad", it, obs_en_cnt, obs_addr_err, l); end
`ifdef MAC_DOT_SAT_FLAG_EN
      n_checks++; if (obs_sat !== ((exp == 16'h7FFF) || (exp == 16'h8001)))
        begin n_fail++; $display("FAIL rand%0d_sat: got %b for result %h", it, obs_sat, exp); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_len4();
    test_cancel();
    test_sat();
    test_len0();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_dot_seq.md
Name: mac_dot_seq

Overview:
- Sequencer that drives the operand side of the 16-bit fixed-point MAC: A/B inputs and the MAC's active-low clear.
- On start, it clears the MAC and reads LEN operand pairs from two synchronous-read operand memories. It streams them into the MAC, then feeds zeros while the MAC pipeline drains.
- It captures the final acc_result and reports it with a one-cycle done pulse.
- Sits between the operand RAMs and the MAC instance; one dot product per command.

Parameters:
- ADDR_W, 8, operand memory address width; max vector length is 2^ADDR_W.
- MAC_LAT, 4, cycles from an operand pair being valid on mac_a/mac_b to its contribution being visible on mac_acc.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  command strobe; sampled only in IDLE
- len  in  ADDR_W+1  number of pairs, 0..2^ADDR_W; sampled with start
- busy  out  1  high from the cycle after start is accepted until DONE
- done  out  1  one-cycle pulse; result valid
- result  out  16  captured accumulator, held until the next capture
- mem_en  out  1  read enable to both operand RAMs
- mem_addr  out  ADDR_W  shared read address
- mem_a_rdata  in  16  A operand, valid the cycle after mem_en
- mem_b_rdata  in  16  B operand, valid the cycle after mem_en
- mac_a  out  16  registered A to the MAC
- mac_b  out  16  registered B to the MAC
- mac_rst_n  out  1  MAC clear, active-low
- mac_acc  in  16  MAC acc_result

Behaviour:
- Reset (rst=0), asynchronous:
  - state=IDLE; busy=0, done=0, result=0, mem_en=0, mem_addr=0, mac_a=0, mac_b=0.
  - mac_rst_n=0, so the MAC is held cleared while rst is low. In IDLE mac_rst_n=1.
- States:
  - IDLE: start && len!=0 -> CLEAR, latch len. start && len==0 -> DONE with result=0; no MAC clear, no memory reads.
  - CLEAR (1 cycle): mac_rst_n=0; mem_en=0; address counter=0 -> FEED.
  - FEED (len cycles): mem_en=1, mem_addr=0,1,...,len-1; after the address len-1 cycle -> DRAIN.
  - DRAIN (MAC_LAT+2 cycles): mem_en=0. On the last DRAIN edge, result<=mac_acc -> DONE.
  - DONE (1 cycle): done=1, busy=0 -> IDLE.
- Operand pipe:
  - A 1-bit read-valid register follows mem_en by one cycle.
  - On each edge: mac_a<=valid?mem_a_rdata:0 and mac_b<=valid?mem_b_rdata:0.
  - Address k therefore appears on mac_a/mac_b two cycles after it is issued.
  - Zero operands outside valid keep the MAC accumulator constant (0*0 contributes 0).
- Latency:
  - The edge that samples start is cycle 0.
  - CLEAR is cycle 1, FEED is cycles 2..len+1, DRAIN is cycles len+2..len+7, done=1 in cycle len+8.
  - For len==0, done=1 in cycle 1.
- Boundaries:
  - start while busy or in DONE: ignored, no queuing.
  - len=2^ADDR_W: all addresses issued; the address counter must not wrap before FEED exits.
  - The MAC saturates internally; mac_dot_seq never alters mac_acc.
  - rst low mid-operation: immediate return to IDLE; result is cleared to 0; no done pulse.
- busy=1 in CLEAR, FEED and DRAIN.

Optional Feature:
- Macro MAC_DOT_SAT_FLAG_EN, defined:
  - Adds output sat_flag (1 bit, reset 0).
  - sat_flag is updated at the capture edge: 1 if mac_acc==16'h7FFF or mac_acc==16'h8001, else 0.
  - It is held with result; len==0 sets it to 0.
- Macro not defined: no sat_flag port and no comparison logic; all other behaviour identical.

Test Plan:
- len=4, all A=B=16'h0200 -> done in cycle 12, result=16'h0800, busy high in cycles 1..11, mac_rst_n low only in cycle 1.
- len=2, A={16'h0200,16'hFE00}, B={16'h0200,16'h0200} -> result=16'h0000, done in cycle 10.
- len=2, A=B=16'h7FFF -> result=16'h7FFF; sat_flag=1 when MAC_DOT_SAT_FLAG_EN is defined.
- len=0 -> done in cycle 1, result=0, mem_en never high, mac_rst_n stays 1.
- start re-pulsed during FEED of a len=3 run -> ignored; single done at cycle 11. Back-to-back start in the first IDLE cycle after DONE -> accepted.
- rst low during the 2nd FEED cycle -> busy=0, result=0, mac_rst_n=0 while low, no done. After release, a new len=1 run (A=B=16'h0200) -> result=16'h0200.
